vx_writeback_arb: RTL and testbench

// - Per-issue-slice writeback producer: collects commit results from the execute units
//   (ALU, LSU, FPU, SFU, ...) and drives the single writeback stream into the GPR slice.
// - Round-robin arbitrates NUM_REQS valid/ready requesters onto one registered wb_* port.
// - The wb_* port has no backpressure; the GPR write side accepts one write every cycle.

---
 rtl/vx_writeback_arb_if.sv | 41 ++++
 rtl/vx_writeback_arb.sv | 141 ++++++++++++++
 tb/tb_vx_writeback_arb.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vx_writeback_arb_if.sv
// Writeback arbiter bus: NUM_REQS execute-unit commit requesters in, one registered GPR write port out.
interface vx_writeback_arb_if #(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NW_BITS     = 2,
    parameter int unsigned NR_BITS     = 5,
    parameter int unsigned PC_BITS     = 32
);
    logic [NUM_REQS-1:0]                  req_valid;
    logic [NUM_REQS-1:0]                  req_ready;
    logic [NUM_REQS*NW_BITS-1:0]          req_wid;
    logic [NUM_REQS*PC_BITS-1:0]          req_pc;
    logic [NUM_REQS*NUM_THREADS-1:0]      req_tmask;
    logic [NUM_REQS*NR_BITS-1:0]          req_rd;
    logic [NUM_REQS-1:0]                  req_wb;
    logic [NUM_REQS*NUM_THREADS*XLEN-1:0] req_data;
    logic [NUM_REQS-1:0]                  req_eop;

    logic                                 wb_valid;
    logic [NW_BITS-1:0]                   wb_wid;
    logic [PC_BITS-1:0]                   wb_pc;
    logic [NUM_THREADS-1:0]               wb_tmask;
    logic [NR_BITS-1:0]                   wb_rd;
    logic                                 wb_eop;
    logic [NUM_THREADS*XLEN-1:0]          wb_data;

    // Requester side (execute units / testbench)
    modport master (
        output req_valid, req_wid, req_pc, req_tmask, req_rd, req_wb, req_data, req_eop,
        input  req_ready,
        input  wb_valid, wb_wid, wb_pc, wb_tmask, wb_rd, wb_eop, wb_data
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_wid, req_pc, req_tmask, req_rd, req_wb, req_data, req_eop,
        output req_ready,
        output wb_valid, wb_wid, wb_pc, wb_tmask, wb_rd, wb_eop, wb_data
    );
endinterface

// File: rtl/vx_writeback_arb.sv
// Round-robin writeback arbiter: one commit per cycle onto a registered, backpressure-free GPR write port.
// Optional WB_ARB_PERF_EN adds perf_wb_writes / perf_wb_stalls counters.
module vx_writeback_arb #(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NW_BITS     = 2,
    parameter int unsigned NR_BITS     = 5,
    parameter int unsigned PC_BITS     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    vx_writeback_arb_if.slave      bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [43:0]            perf_wb_writes,
    output logic [43:0]            perf_wb_stalls
`endif
);
    localparam int unsigned PTR_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int unsigned DATA_W = NUM_THREADS * XLEN;

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       rr_ptr_next;
    logic [PTR_W-1:0]       winner;
    logic                   grant;

    logic [NW_BITS-1:0]     sel_wid;
    logic [PC_BITS-1:0]     sel_pc;
    logic [NUM_THREADS-1:0] sel_tmask;
    logic [NR_BITS-1:0]     sel_rd;
    logic                   sel_wb;
    logic                   sel_eop;
    logic [DATA_W-1:0]      sel_data;

    // Requester index k slots after the pointer, wrapped into 0..NUM_REQS-1.
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] ptr, input int unsigned k);
        int unsigned s;
        s = 32'(ptr) + k;
        if (s >= NUM_REQS) begin
            s = s - NUM_REQS;
        end
        return PTR_W'(s);
    endfunction

    // First valid requester at or after rr_ptr; reset suppresses any grant.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            if (!grant && bus.req_valid[rr_index(rr_ptr, k)]) begin
                grant  = 1'b1;
                winner = rr_index(rr_ptr, k);
            end
        end
        if (reset) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant) begin
            if (winner == PTR_W'(NUM_REQS - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = winner + PTR_W'(1);
            end
        end
    end

    always_comb begin
        sel_wid   = '0;
        sel_pc    = '0;
        sel_tmask = '0;
        sel_rd    = '0;
        sel_wb    = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (PTR_W'(i) == winner) begin
                sel_wid   = bus.req_wid[i*NW_BITS +: NW_BITS];
                sel_pc    = bus.req_pc[i*PC_BITS +: PC_BITS];
                sel_tmask = bus.req_tmask[i*NUM_THREADS +: NUM_THREADS];
                sel_rd    = bus.req_rd[i*NR_BITS +: NR_BITS];
                sel_wb    = bus.req_wb[i];
                sel_eop   = bus.req_eop[i];
                sel_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Fields load on every grant, even req_wb=0 commits; only the strobe reflects req_wb.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_wid   <= '0;
            bus.wb_pc    <= '0;
            bus.wb_tmask <= '0;
            bus.wb_rd    <= '0;
            bus.wb_eop   <= 1'b0;
            bus.wb_data  <= '0;
        end else begin
            rr_ptr       <= rr_ptr_next;
            bus.wb_valid <= grant && sel_wb;
            if (grant) begin
                bus.wb_wid   <= sel_wid;
                bus.wb_pc    <= sel_pc;
                bus.wb_tmask <= sel_tmask;
                bus.wb_rd    <= sel_rd;
                bus.wb_eop   <= sel_eop;
                bus.wb_data  <= sel_data;
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    logic multi_valid;

    assign multi_valid = (bus.req_valid & (bus.req_valid - NUM_REQS'(1))) != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_wb_writes <= '0;
            perf_wb_stalls <= '0;
        end else begin
            perf_wb_writes <= perf_wb_writes + 44'(bus.wb_valid);
            perf_wb_stalls <= perf_wb_stalls + 44'(multi_valid);
        end
    end
`endif

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Bench for vx_writeback_arb: table-driven grant vectors plus hand sequences, writeback checked via a scoreboard queue.
module tb_vx_writeback_arb;
    localparam int NR  = 4;
    localparam int NT  = 4;
    localparam int XL  = 32;
    localparam int NWB = 2;
    localparam int NRB = 5;
    localparam int PCB = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vx_writeback_arb_if #(
        .NUM_REQS(NR), .NUM_THREADS(NT), .XLEN(XL),
        .NW_BITS(NWB), .NR_BITS(NRB), .PC_BITS(PCB)
    ) bus ();

`ifdef WB_ARB_PERF_EN
    logic [43:0] perf_wb_writes;
    logic [43:0] perf_wb_stalls;
`endif

    vx_writeback_arb #(
        .NUM_REQS(NR), .NUM_THREADS(NT), .XLEN(XL),
        .NW_BITS(NWB), .NR_BITS(NRB), .PC_BITS(PCB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_wb_writes(perf_wb_writes),
        .perf_wb_stalls(perf_wb_stalls)
`endif
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] wb;
        logic [3:0] ready;
    } vec_t;

    typedef struct packed {
        logic         valid;
        logic [1:0]   wid;
        logic [31:0]  pc;
        logic [3:0]   tmask;
        logic [4:0]   rd;
        logic         eop;
        logic [127:0] data;
    } wb_exp_t;

    int checks   = 0;
    int failures = 0;

    wb_exp_t     sb[$];
    wb_exp_t     last;
    vec_t        tbl[18];

    logic [1:0]   p_wid[NR];
    logic [31:0]  p_pc[NR];
    logic [3:0]   p_tmask[NR];
    logic [4:0]   p_rd[NR];
    logic         p_eop[NR];
    logic [127:0] p_data[NR];
    int unsigned  seq[NR];
    bit           spec_mode = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Payload of a requester only changes after it has been accepted (seq bumps on grant).
    task automatic fill_payload();
        for (int i = 0; i < NR; i++) begin
            p_wid[i]   = 2'(i + int'(seq[i]));
            p_pc[i]    = {16'(i), 16'(seq[i])};
            p_tmask[i] = 4'(int'(seq[i]) + i + 1);
            p_rd[i]    = 5'(i * 7 + int'(seq[i]));
            p_eop[i]   = seq[i][0];
            for (int l = 0; l < NT; l++) begin
                p_data[i][l*32 +: 32] = p_pc[i] ^ (32'h0101_0101 * 32'(l + 1));
            end
            if (spec_mode && i == 2) begin
                p_wid[i]  = 2'd1;
                p_rd[i]   = 5'd5;
                p_eop[i]  = 1'b1;
                p_data[i] = {4{32'hA5A5_A5A5}};
            end
            bus.req_wid[i*NWB +: NWB]         = p_wid[i];
            bus.req_pc[i*PCB +: PCB]          = p_pc[i];
            bus.req_tmask[i*NT +: NT]         = p_tmask[i];
            bus.req_rd[i*NRB +: NRB]          = p_rd[i];
            bus.req_eop[i]                    = p_eop[i];
            bus.req_data[i*NT*XL +: NT*XL]    = p_data[i];
        end
    endtask

    task automatic check_wb();
        wb_exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=empty required=entry (t=%0t)", $time);
            return;
        end
        e = sb.pop_front();
        chk("wb_valid", 128'(bus.wb_valid), 128'(e.valid));
        chk("wb_wid",   128'(bus.wb_wid),   128'(e.wid));
        chk("wb_pc",    128'(bus.wb_pc),    128'(e.pc));
        chk("wb_tmask", 128'(bus.wb_tmask), 128'(e.tmask));
        chk("wb_rd",    128'(bus.wb_rd),    128'(e.rd));
        chk("wb_eop",   128'(bus.wb_eop),   128'(e.eop));
        chk("wb_data",  bus.wb_data,        e.data);
    endtask

    // One clock: check the registered output from the previous edge, drive new inputs,
    // check the combinational grant, and queue the writeback the next edge must produce.
    task automatic step(input logic rst_i, input logic [3:0] v, input logic [3:0] w, input logic [3:0] rdy);
        wb_exp_t e;
        int      idx;
        @(negedge clk);
        check_wb();
        reset = rst_i;
        fill_payload();
        bus.req_valid = v;
        bus.req_wb    = w;
        #1;
        chk("req_ready", 128'(bus.req_ready), 128'(rdy));
        if (rst_i) begin
            e    = '0;
            last = e;
        end else if (rdy != 4'b0000) begin
            idx = 0;
            for (int i = 0; i < NR; i++) begin
                if (rdy[i]) idx = i;
            end
            e.valid = w[idx];
            e.wid   = p_wid[idx];
            e.pc    = p_pc[idx];
            e.tmask = p_tmask[idx];
            e.rd    = p_rd[idx];
            e.eop   = p_eop[idx];
            e.data  = p_data[idx];
            last    = e;
            seq[idx] = seq[idx] + 1;
        end else begin
            e       = last;
            e.valid = 1'b0;
        end
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // {valid, wb, expected one-hot ready}; rr_ptr starts at 0 after reset
        tbl[0]  = '{4'b1111, 4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b1111, 4'b0001};
        tbl[5]  = '{4'b1111, 4'b1111, 4'b0010};
        tbl[6]  = '{4'b1111, 4'b1111, 4'b0100};
        tbl[7]  = '{4'b1111, 4'b1111, 4'b1000};
        tbl[8]  = '{4'b0000, 4'b1111, 4'b0000};
        tbl[9]  = '{4'b0110, 4'b1111, 4'b0010};
        tbl[10] = '{4'b0110, 4'b1111, 4'b0100};
        tbl[11] = '{4'b1001, 4'b1111, 4'b1000};
        tbl[12] = '{4'b1001, 4'b1111, 4'b0001};
        tbl[13] = '{4'b0100, 4'b0000, 4'b0100};
        tbl[14] = '{4'b0001, 4'b1111, 4'b0001};
        tbl[15] = '{4'b1100, 4'b1011, 4'b0100};
        tbl[16] = '{4'b1100, 4'b1011, 4'b1000};
        tbl[17] = '{4'b0000, 4'b0000, 4'b0000};

        for (int i = 0; i < NR; i++) seq[i] = 0;
        bus.req_valid = '0;
        bus.req_wb    = '0;
        fill_payload();
        repeat (2) @(posedge clk);
        last = '0;
        sb.push_back('0);

        // Reset holds ready low even with every requester valid
        step(1'b1, 4'b1111, 4'b1111, 4'b0000);

        for (int i = 0; i < 18; i++) begin
            step(1'b0, tbl[i].valid, tbl[i].wb, tbl[i].ready);
        end

        // Single request with fixed payload, then a wb=0 / eop=1 commit from the same requester
        spec_mode = 1'b1;
        step(1'b0, 4'b0100, 4'b1111, 4'b0100);
        step(1'b0, 4'b0100, 4'b0000, 4'b0100);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000);
        spec_mode = 1'b0;

        // Reset the cycle after a grant: writeback dropped, pointer restarts at 0
        step(1'b0, 4'b0010, 4'b1111, 4'b0010);
        step(1'b1, 4'b1111, 4'b1111, 4'b0000);
        step(1'b0, 4'b0110, 4'b1111, 4'b0010);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000);

`ifdef WB_ARB_PERF_EN
        step(1'b1, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'b1111, 4'b1111, 4'(1 << (k % 4)));
        end
        step(1'b0, 4'b0000, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        check_wb();
        chk("perf_wb_writes", 128'(perf_wb_writes), 128'(10));
        chk("perf_wb_stalls", 128'(perf_wb_stalls), 128'(10));
`else
        @(negedge clk);
        check_wb();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
